// File: rtl/serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// serial_adder_nbit
//
// Bit-serial unsigned adder. One full-adder cell plus a carry flip-flop is
// reused over WIDTH clocks. The operands and the carry-in are captured on an
// accepted start and processed LSB-first, one bit per clock. The N-bit sum
// and the carry-out are presented together with a one-cycle done pulse.
//
// Parameters
//   WIDTH   operand/sum width in bits (>= 2), default 8
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled at a rising edge when not busy
//   a       in   WIDTH  operand A, captured on an accepted start
//   b       in   WIDTH  operand B, captured on an accepted start
//   cin     in   1      carry-in, captured on an accepted start
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle pulse, sum/cout valid
//   sum     out  WIDTH  result, held until the next result is ready
//   cout    out  1      final carry, held with sum
//   ovf     out  1      two's-complement overflow (only with the macro below)
//
// Build option
//   SERIAL_ADDER_OVF_EN  adds the ovf output. It is the carry into the MSB
//                        XOR the carry out of the MSB, registered together
//                        with sum when the result is ready.
//
// State table
//   state | meaning
//   IDLE  | waiting for start, busy=0, done=0
//   SHIFT | one result bit per clock, busy=1
//   DONE  | result valid, done=1 for one cycle, start accepted again
// ---------------------------------------------------------------------------
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;     // partial sum, filled from the MSB side
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             s_bit;
    logic             carry_d;
    logic [WIDTH-1:0] sh_d;
    logic             accept;
    logic             last_bit;

    // Full-adder cell on the current LSBs of the operand shift registers.
    always_comb begin
        s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        sh_d     = {s_bit, sh_q[WIDTH-1:1]};
        accept   = start && (state_q != SHIFT);
        last_bit = (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                // Accepted from IDLE or directly from DONE (back-to-back).
                state_q <= SHIFT;
                a_q     <= a;
                b_q     <= b;
                sh_q    <= '0;
                carry_q <= cin;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    SHIFT: begin
                        a_q     <= a_q >> 1;
                        b_q     <= b_q >> 1;
                        sh_q    <= sh_d;
                        carry_q <= carry_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (last_bit) begin
                            // The visible result registers only change here,
                            // so partial sums never reach the outputs.
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sum_q   <= sh_d;
                            cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                            // carry_q is still the carry into the MSB here.
                            ovf_q   <= carry_q ^ carry_d;
`endif
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
